// File: rtl/pipe_hold_ctrl_if.sv
// pipe_hold_ctrl_if: request side (EX jump, hold requesters, debug halt) and control side
// (per-stage stall/flush, pc load) of the tinyriscv pipeline control unit.
interface pipe_hold_ctrl_if #(
    parameter int STAGES  = 3,
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int SW      = $clog2(STAGES)
);
    logic                   jump_flag_i;
    logic [AW-1:0]          jump_addr_i;
    logic [NUM_REQ-1:0]     hold_req_i;
    logic [NUM_REQ*SW-1:0]  hold_lvl_i;
    logic                   halt_req_i;
    logic                   halt_ack_o;
    logic [STAGES-1:0]      stall_o;
    logic [STAGES-1:0]      flush_o;
    logic                   jump_flag_o;
    logic [AW-1:0]          jump_addr_o;

    // The requesting side (ex/rib/clint/jtag plus the stage registers it steers)
    modport master (
        output jump_flag_i, jump_addr_i, hold_req_i, hold_lvl_i, halt_req_i,
        input  halt_ack_o, stall_o, flush_o, jump_flag_o, jump_addr_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_req_i, hold_lvl_i, halt_req_i,
        output halt_ack_o, stall_o, flush_o, jump_flag_o, jump_addr_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: merges EX jumps and per-stage hold requests into stall/flush vectors and runs
// the debug halt/drain/resume FSM. Optional perf counters are enabled with CTRL_PERF_CNT_EN.
module pipe_hold_ctrl #(
    parameter int STAGES  = 3,
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int SW      = $clog2(STAGES)
) (
    input  logic            clk,
    input  logic            rst,
    pipe_hold_ctrl_if.slave bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [STAGES-1:0] FLUSH_ALL = {{(STAGES-1){1'b1}}, 1'b0};
    localparam logic [SW-1:0]     LVL_MAX   = SW'(STAGES-1);

    state_e              state_q, state_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic                pend_vld_q, pend_vld_d;
    logic [AW-1:0]       pend_addr_q, pend_addr_d;

    logic                any_hold;
    logic [SW-1:0]       hold_lvl;
    logic [STAGES-1:0]   hold_stall;
    logic [STAGES-1:0]   hold_flush;

    logic [STAGES-1:0]   stall;
    logic [STAGES-1:0]   flush;
    logic                jump_flag;
    logic [AW-1:0]       jump_addr;
    logic                halt_ack;

    // Deepest requested hold wins; out-of-range levels are clamped to the EX input register.
    always_comb begin
        any_hold   = |bus.hold_req_i;
        hold_lvl   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.hold_req_i[k] && (bus.hold_lvl_i[k*SW +: SW] > hold_lvl)) begin
                hold_lvl = bus.hold_lvl_i[k*SW +: SW];
            end
        end
        if (hold_lvl > LVL_MAX) begin
            hold_lvl = LVL_MAX;
        end
        hold_stall = '0;
        hold_flush = '0;
        for (int i = 0; i < STAGES; i++) begin
            hold_stall[i] = any_hold && (i <= int'(hold_lvl));
            hold_flush[i] = any_hold && (i == int'(hold_lvl) + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            RUN: begin
                if (bus.halt_req_i) begin
                    state_d = DRAIN;
                    cnt_d   = LVL_MAX;
                end
            end
            DRAIN: begin
                if (!bus.halt_req_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (bus.jump_flag_i) begin
                    // Pipeline is flushed now; the target is replayed on resume.
                    state_d     = HALTED;
                    cnt_d       = '0;
                    pend_vld_d  = 1'b1;
                    pend_addr_d = bus.jump_addr_i;
                end else if (!any_hold) begin
                    cnt_d = cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!bus.halt_req_i) begin
                    state_d    = RUN;
                    pend_vld_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        stall     = '0;
        flush     = '0;
        jump_flag = 1'b0;
        jump_addr = '0;
        halt_ack  = 1'b0;
        case (state_q)
            RUN: begin
                jump_addr = bus.jump_addr_i;
                if (bus.jump_flag_i) begin
                    jump_flag = 1'b1;
                    flush     = FLUSH_ALL;
                end else begin
                    stall = hold_stall;
                    flush = hold_flush;
                end
            end
            DRAIN: begin
                if (bus.jump_flag_i) begin
                    stall = {{(STAGES-1){1'b0}}, 1'b1};
                    flush = FLUSH_ALL;
                end else begin
                    stall = hold_stall | {{(STAGES-1){1'b0}}, 1'b1};
                    flush = hold_flush | {{(STAGES-2){1'b0}}, 2'b10};
                end
            end
            HALTED: begin
                if (bus.halt_req_i) begin
                    stall    = '1;
                    halt_ack = 1'b1;
                end else if (pend_vld_q) begin
                    jump_flag = 1'b1;
                    jump_addr = pend_addr_q;
                    flush     = FLUSH_ALL;
                end
            end
            default: begin
                stall = '0;
            end
        endcase
    end

    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.jump_flag_o = jump_flag;
    assign bus.jump_addr_o = jump_addr;
    assign bus.halt_ack_o  = halt_ack;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((|flush) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb_pipe_hold_ctrl: scenario tasks plus a randomized run, all checked against a
// behavioural model of the halt/drain/resume rules and the hold merge.
module tb_pipe_hold_ctrl;

    localparam int STAGES  = 3;
    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int SW      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_next = 1'b1;

    always #5 clk = ~clk;

    pipe_hold_ctrl_if #(.STAGES(STAGES), .NUM_REQ(NUM_REQ), .AW(AW), .SW(SW)) bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hold_ctrl #(.STAGES(STAGES), .NUM_REQ(NUM_REQ), .AW(AW), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 = running, 1 = draining, 2 = halted
    int          m_state = 0;
    int          m_left  = 0;
    bit          m_pend_vld = 1'b0;
    logic [31:0] m_pend_addr = '0;

    logic [STAGES-1:0] exp_stall, exp_flush;
    logic              exp_jf, exp_ack;
    logic [31:0]       exp_ja;
    bit                exp_stall_known;

    task automatic predict();
        int lvl;
        bit any;
        logic [STAGES-1:0] h_stall, h_flush, full;
        any = |bus.hold_req_i;
        lvl = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.hold_req_i[k] && int'(bus.hold_lvl_i[k*SW +: SW]) > lvl) lvl = int'(bus.hold_lvl_i[k*SW +: SW]);
        end
        if (lvl > STAGES - 1) lvl = STAGES - 1;
        h_stall = any ? STAGES'((1 << (lvl + 1)) - 1) : '0;
        h_flush = (any && (lvl + 1 < STAGES)) ? STAGES'(1 << (lvl + 1)) : '0;
        full    = STAGES'((1 << STAGES) - 2);
        exp_stall = '0; exp_flush = '0; exp_jf = 1'b0; exp_ja = '0; exp_ack = 1'b0; exp_stall_known = 1'b1;
        case (m_state)
            0: begin
                if (bus.jump_flag_i) begin
                    exp_jf = 1'b1; exp_ja = bus.jump_addr_i; exp_flush = full;
                end else begin
                    exp_stall = h_stall; exp_flush = h_flush;
                end
            end
            1: begin
                if (bus.jump_flag_i) begin
                    exp_flush = full; exp_stall_known = 1'b0;
                end else begin
                    exp_stall = h_stall | STAGES'(1); exp_flush = h_flush | STAGES'(2);
                end
            end
            default: begin
                if (bus.halt_req_i) begin
                    exp_stall = '1; exp_ack = 1'b1;
                end else if (m_pend_vld) begin
                    exp_jf = 1'b1; exp_ja = m_pend_addr; exp_flush = full;
                end
            end
        endcase
    endtask

    task automatic advance();
        if (rst) begin
            m_state = 0; m_left = 0; m_pend_vld = 1'b0; m_pend_addr = '0;
        end else begin
            case (m_state)
                0: if (bus.halt_req_i) begin m_state = 1; m_left = STAGES - 1; end
                1: begin
                    if (!bus.halt_req_i) m_state = 0;
                    else if (bus.jump_flag_i) begin m_state = 2; m_pend_vld = 1'b1; m_pend_addr = bus.jump_addr_i; end
                    else if (bus.hold_req_i == '0) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_state = 2;
                    end
                end
                default: if (!bus.halt_req_i) begin m_state = 0; m_pend_vld = 1'b0; end
            endcase
        end
    endtask

    task automatic drive(input logic jf, input logic [31:0] ja, input logic [3:0] hr,
                         input logic [7:0] hl, input logic halt);
        @(negedge clk);
        rst = rst_next;
        bus.jump_flag_i = jf;
        bus.jump_addr_i = ja;
        bus.hold_req_i  = hr;
        bus.hold_lvl_i  = hl;
        bus.halt_req_i  = halt;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
    endtask

    task automatic test_reset();
        rst_next = 1'b1;
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (bus.stall_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_stall got %b want 000", bus.stall_o); end
        checks++; if (bus.flush_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_flush got %b want 000", bus.flush_o); end
        checks++; if (bus.jump_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_jflag got %b want 0", bus.jump_flag_o); end
        checks++; if (bus.jump_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_jaddr got %h want 0", bus.jump_addr_o); end
        checks++; if (bus.halt_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", bus.halt_ack_o); end
`ifdef CTRL_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (flush_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_flush_cnt got %0d want 0", flush_cnt); end
`endif
        tick();
        rst_next = 1'b0;
    endtask

    task automatic test_hold_merge();
        drive(0, 0, 4'b0110, 8'b00_01_00_00, 0);
        checks++; if (bus.stall_o !== exp_stall) begin errors++; $display("[TB] FAIL merge_stall got %b want %b", bus.stall_o, exp_stall); end
        checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL merge_flush got %b want %b", bus.flush_o, exp_flush); end
        tick();
        drive(0, 0, 4'b0000, 8'b00_01_00_00, 0);
        checks++; if (bus.stall_o !== exp_stall) begin errors++; $display("[TB] FAIL release_stall got %b want %b", bus.stall_o, exp_stall); end
        checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL release_flush got %b want %b", bus.flush_o, exp_flush); end
        tick();
    endtask

    task automatic test_jump_vs_hold();
        drive(1, 32'h0000_0100, 4'b0001, 8'b00_00_00_10, 0);
        checks++; if (bus.jump_flag_o !== exp_jf) begin errors++; $display("[TB] FAIL jvh_jflag got %b want %b", bus.jump_flag_o, exp_jf); end
        checks++; if (bus.jump_addr_o !== exp_ja) begin errors++; $display("[TB] FAIL jvh_jaddr got %h want %h", bus.jump_addr_o, exp_ja); end
        checks++; if (bus.stall_o !== exp_stall) begin errors++; $display("[TB] FAIL jvh_stall got %b want %b", bus.stall_o, exp_stall); end
        checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL jvh_flush got %b want %b", bus.flush_o, exp_flush); end
        tick();
    endtask

    // hold_cycles: number of leading drain cycles with a level-0 hold active
    task automatic test_halt(input int hold_cycles, input int want_latency);
        int n;
        drive(0, 0, 0, 0, 1);
        tick();
        n = 1;
        while (n < 20) begin
            drive(0, 0, (n <= hold_cycles) ? 4'b0001 : 4'b0000, 0, 1);
            checks++; if (bus.halt_ack_o !== exp_ack) begin errors++; $display("[TB] FAIL halt_ack got %b want %b", bus.halt_ack_o, exp_ack); end
            checks++; if (bus.stall_o !== exp_stall) begin errors++; $display("[TB] FAIL halt_stall got %b want %b", bus.stall_o, exp_stall); end
            checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL halt_flush got %b want %b", bus.flush_o, exp_flush); end
            if (bus.halt_ack_o === 1'b1) break;
            tick();
            n++;
        end
        checks++; if (n !== want_latency) begin errors++; $display("[TB] FAIL halt_latency got %0d want %0d", n, want_latency); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (bus.halt_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL resume_ack got %b want 0", bus.halt_ack_o); end
        checks++; if (bus.jump_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL resume_jflag got %b want 0", bus.jump_flag_o); end
        tick();
    endtask

    task automatic test_jump_in_drain();
        drive(0, 0, 0, 0, 1); tick();
        drive(1, 32'h0000_2000, 0, 0, 1);
        checks++; if (bus.jump_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL drainjump_jflag got %b want 0", bus.jump_flag_o); end
        checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL drainjump_flush got %b want %b", bus.flush_o, exp_flush); end
        tick();
        drive(0, 0, 0, 0, 1);
        checks++; if (bus.halt_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL drainjump_halted got %b want 1", bus.halt_ack_o); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (bus.jump_flag_o !== 1'b1) begin errors++; $display("[TB] FAIL replay_jflag got %b want 1", bus.jump_flag_o); end
        checks++; if (bus.jump_addr_o !== 32'h0000_2000) begin errors++; $display("[TB] FAIL replay_jaddr got %h want 00002000", bus.jump_addr_o); end
        checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL replay_flush got %b want %b", bus.flush_o, exp_flush); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (bus.jump_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL replay_once got %b want 0", bus.jump_flag_o); end
        tick();
    endtask

    task automatic test_reset_mid_halt();
        drive(0, 0, 0, 0, 1); tick();
        drive(1, 32'h0000_3000, 0, 0, 1); tick();
        rst_next = 1'b1;
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        checks++; if ({bus.stall_o, bus.flush_o, bus.jump_flag_o, bus.halt_ack_o} !== 8'h00) begin
            errors++; $display("[TB] FAIL midrst_outputs got %b_%b_%b_%b want all 0", bus.stall_o, bus.flush_o, bus.jump_flag_o, bus.halt_ack_o);
        end
`ifdef CTRL_PERF_CNT_EN
        checks++; if ((stall_cnt | flush_cnt) !== 32'h0) begin errors++; $display("[TB] FAIL midrst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
        tick();
        rst_next = 1'b0;
        for (int n = 0; n < 10; n++) begin
            drive(0, 0, 0, 0, 1);
            if (exp_ack) break;
            tick();
        end
        checks++; if (bus.halt_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_halt got %b want 1", bus.halt_ack_o); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (bus.jump_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_noreplay got %b want 0", bus.jump_flag_o); end
        tick();
    endtask

    task automatic test_random();
        logic halt = 1'b0;
        logic [7:0] hl;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            for (int k = 0; k < NUM_REQ; k++) hl[k*SW +: SW] = 2'($urandom_range(0, 2));
            drive(($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, hl, halt);
            if (exp_stall_known) begin
                checks++; if (bus.stall_o !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall it=%0d got %b want %b", it, bus.stall_o, exp_stall); end
            end
            checks++; if (bus.flush_o !== exp_flush) begin errors++; $display("[TB] FAIL rnd_flush it=%0d got %b want %b", it, bus.flush_o, exp_flush); end
            checks++; if (bus.jump_flag_o !== exp_jf) begin errors++; $display("[TB] FAIL rnd_jflag it=%0d got %b want %b", it, bus.jump_flag_o, exp_jf); end
            if (exp_jf) begin
                checks++; if (bus.jump_addr_o !== exp_ja) begin errors++; $display("[TB] FAIL rnd_jaddr it=%0d got %h want %h", it, bus.jump_addr_o, exp_ja); end
            end
            checks++; if (bus.halt_ack_o !== exp_ack) begin errors++; $display("[TB] FAIL rnd_ack it=%0d got %b want %b", it, bus.halt_ack_o, exp_ack); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_hold_merge();
        test_jump_vs_hold();
        test_halt(0, 3);
        test_halt(2, 5);
        test_jump_in_drain();
        test_reset_mid_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
